// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and instruction-kind enum, used by the decoder and the
// program loader so both agree on opcode/funct values.
package mips_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_BNE  = 4'd8,
    KIND_ADDI = 4'd9,
    KIND_SLTI = 4'd10,
    KIND_J    = 4'd11,
    KIND_JAL  = 4'd12,
    KIND_LB   = 4'd13
  } instr_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_FULL
  } ld_state_t;

  typedef struct packed {
    instr_kind_t  kind;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [15:0]  imm;
    logic [25:0]  target;
  } enc_req_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  function automatic logic [31:0] r_word(input enc_req_t r, input logic [5:0] fn);
    return {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(input enc_req_t r, input logic [5:0] op);
    return {op, r.rs, r.rt, r.imm};
  endfunction

  function automatic logic [31:0] j_word(input enc_req_t r, input logic [5:0] op);
    return {op, r.target};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational symbolic-request -> 32-bit MIPS word encoder. Undefined kinds yield a
// zero word (NOP) and raise illegal.
module instr_encode
  import mips_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.kind)
      KIND_ADD:  word = r_word(req, FN_ADD);
      KIND_SUB:  word = r_word(req, FN_SUB);
      KIND_AND:  word = r_word(req, FN_AND);
      KIND_OR:   word = r_word(req, FN_OR);
      KIND_SLT:  word = r_word(req, FN_SLT);
      KIND_LW:   word = i_word(req, OP_LW);
      KIND_SW:   word = i_word(req, OP_SW);
      KIND_BEQ:  word = i_word(req, OP_BEQ);
      KIND_BNE:  word = i_word(req, OP_BNE);
      KIND_ADDI: word = i_word(req, OP_ADDI);
      KIND_SLTI: word = i_word(req, OP_SLTI);
      KIND_LB:   word = i_word(req, OP_LB);
      KIND_J:    word = j_word(req, OP_J);
      KIND_JAL:  word = j_word(req, OP_JAL);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic requests and streams them into imem through a registered write port.
// Define ENC_ILLEGAL_TRAP_EN to drop undefined kinds and flag error instead of writing a NOP.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  ld_state_t         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  enc_req_t    req;
  logic [31:0] enc_word;
  logic        illegal;
  logic        drop;
  logic        accept;

  assign req = '{kind: instr_kind_t'(in_kind), rs: in_rs, rt: in_rt, rd: in_rd,
                 imm: in_imm, target: in_target};

  instr_encode u_enc (
    .req     (req),
    .word    (enc_word),
    .illegal (illegal)
  );

`ifdef ENC_ILLEGAL_TRAP_EN
  assign drop = illegal;
`else
  // Undefined kinds are already encoded as zero, so they are written like any other word.
  assign drop = 1'b0 & illegal;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    done_d   = done_q;
    error_d  = error_q;
    in_ready = (state_q == S_LOAD) && (count_q < DEPTH_C);
    accept   = in_valid && in_ready;

    if (clear) begin
      state_d = S_IDLE;
      addr_d  = BASE_C;
      ptr_d   = BASE_C;
      count_d = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LOAD;
        S_LOAD: begin
          if (accept) begin
            if (drop) begin
              error_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              ptr_d   = ptr_q + 1'b1;
              wdata_d = enc_word;
              count_d = count_q + 1'b1;
            end
            // A final word that also fills memory reports DONE rather than FULL.
            if (in_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (count_d == DEPTH_C) begin
              state_d = S_FULL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_C;
      ptr_q   <= BASE_C;
      wdata_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed program-load scenarios plus a randomized run
// checked against a loader model (word list, write pointer, sticky flags).
module tb_instr_encoder_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int BASE   = 0;
`ifdef ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_last;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done, error;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .done(done), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Loader model: words written so far, next address, whether loading has stopped.
  bit          m_idle, m_stop, m_done, m_err, m_rdy;
  int          m_words, m_ptr;
  bit          exp_we;
  int          exp_addr;
  logic [31:0] exp_wdata;
  logic        obs_rdy;
  bit          exp_rdy;

  function automatic logic [31:0] ref_enc(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    int op, fn;
    logic [31:0] r, i, j;
    op = 0; fn = 0;
    case (k)
      0: fn = 32; 1: fn = 34; 2: fn = 36; 3: fn = 37; 4: fn = 42;
      5: op = 35; 6: op = 43; 7: op = 4; 8: op = 5; 9: op = 8; 10: op = 10; 13: op = 32;
      11: op = 2; 12: op = 3;
      default: return 32'h0;
    endcase
    r = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
    i = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    j = (32'(op) << 26) | 32'(tgt);
    if (k <= 4) return r;
    if (k == 11 || k == 12) return j;
    return i;
  endfunction

  task automatic tick(input logic rst, clr, v, input logic [3:0] k,
                      input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    bit acc, ill;
    reset = rst; clear = clr; in_valid = v; in_kind = k; in_rs = rs; in_rt = rt;
    in_rd = rd; in_imm = imm; in_target = tgt; in_last = last;
    @(negedge clk);
    obs_rdy = in_ready;
    exp_rdy = m_rdy;
    @(posedge clk);
    #1;
    acc    = v && m_rdy;
    exp_we = 1'b0;
    if (rst) begin
      m_idle = 1; m_stop = 0; m_done = 0; m_err = 0; m_words = 0; m_ptr = BASE;
      exp_addr = BASE; exp_wdata = 32'h0;
    end else if (clr) begin
      m_idle = 1; m_stop = 0; m_done = 0; m_err = 0; m_words = 0; m_ptr = BASE;
      exp_addr = BASE;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (acc) begin
      ill = (k > 4'd13);
      if (TRAP && ill) m_err = 1;
      else begin
        exp_we = 1; exp_addr = m_ptr; exp_wdata = ref_enc(k, rs, rt, rd, imm, tgt);
        m_ptr = (m_ptr + 1) % (1 << ADDR_W); m_words++;
      end
      if (last) begin m_done = 1; m_stop = 1; end
      else if (m_words == DEPTH) m_stop = 1;
    end
    m_rdy = !m_idle && !m_stop;
  endtask

  task automatic idle_cycle();
    tick(0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
  endtask

  task automatic restart();
    tick(0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
    idle_cycle();
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
    tick(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b0 || in_ready !== 1'b0 || count !== '0 || done !== 1'b0 ||
        error !== 1'b0 || imem_addr !== ADDR_W'(BASE) || imem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: we=%b rdy=%b cnt=%0d done=%b err=%b addr=%0d wdata=%h, required all zero/BASE",
               imem_we, in_ready, count, done, error, imem_addr, imem_wdata);
    end
    idle_cycle();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_idle: got %b required 1", in_ready);
    end
    // Reset mid-load: request accepted, then reset asserted in the next cycle.
    tick(0, 0, 1, 4'd9, 5'd1, 5'd2, 5'd0, 16'h1, 26'd0, 0);
    tick(1, 0, 1, 4'd9, 5'd1, 5'd2, 5'd0, 16'h1, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b0 || count !== '0) begin
      n_bad++; $display("FAIL reset_abort: we=%b cnt=%0d required 0/0", imem_we, count);
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_addi();
    tick(0, 0, 1, 4'd9, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h20080005 || count !== 7'd1) begin
      n_bad++;
      $display("FAIL addi: we=%b addr=%0d wdata=%h cnt=%0d required 1/0/20080005/1",
               imem_we, imem_addr, imem_wdata, count);
    end
    idle_cycle();
    n_cmp++;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL we_one_cycle: got %b required 0", imem_we); end
  endtask

  task automatic test_back_to_back();
    restart();
    tick(0, 0, 1, 4'd0, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h01095020) begin
      n_bad++; $display("FAIL b2b_add: we=%b addr=%0d wdata=%h required 1/0/01095020", imem_we, imem_addr, imem_wdata);
    end
    tick(0, 0, 1, 4'd5, 5'd29, 5'd2, 5'd0, 16'd4, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h8FA20004 || count !== 7'd2) begin
      n_bad++; $display("FAIL b2b_lw: we=%b addr=%0d wdata=%h cnt=%0d required 1/1/8fa20004/2",
                        imem_we, imem_addr, imem_wdata, count);
    end
  endtask

  task automatic test_last();
    tick(0, 0, 1, 4'd11, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1);
    n_cmp++;
    if (imem_we !== 1'b1 || imem_wdata !== 32'h08000010 || done !== 1'b1) begin
      n_bad++; $display("FAIL last_j: we=%b wdata=%h done=%b required 1/08000010/1", imem_we, imem_wdata, done);
    end
    tick(0, 0, 1, 4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0 || imem_we !== 1'b0 || done !== 1'b1) begin
      n_bad++; $display("FAIL done_stall: rdy=%b we=%b done=%b required 0/0/1", obs_rdy, imem_we, done);
    end
  endtask

  task automatic test_full();
    int writes, bad_addr;
    writes = 0; bad_addr = 0;
    restart();
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 0, 1, 4'(i % 14), 5'(i), 5'(i + 1), 5'(i + 2), 16'(i * 3), 26'(i), 0);
      if (imem_we === 1'b1) begin
        writes++;
        if (imem_addr !== 6'(i) || imem_wdata !== exp_wdata) bad_addr++;
      end
    end
    n_cmp++;
    if (writes != DEPTH || bad_addr != 0 || count !== 7'(DEPTH) || imem_addr !== 6'(DEPTH - 1)) begin
      n_bad++; $display("FAIL full_stream: writes=%0d badwords=%0d cnt=%0d lastaddr=%0d required %0d/0/%0d/%0d",
                        writes, bad_addr, count, imem_addr, DEPTH, DEPTH, DEPTH - 1);
    end
    tick(0, 0, 1, 4'd9, 5'd1, 5'd1, 5'd0, 16'd1, 26'd0, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0 || imem_we !== 1'b0 || count !== 7'(DEPTH) || done !== 1'b0) begin
      n_bad++; $display("FAIL full_stall: rdy=%b we=%b cnt=%0d done=%b required 0/0/%0d/0", obs_rdy, imem_we, count, done, DEPTH);
    end
  endtask

  task automatic test_full_last();
    restart();
    for (int i = 0; i < DEPTH; i++)
      tick(0, 0, 1, 4'd1, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0, (i == DEPTH - 1) ? 1'b1 : 1'b0);
    n_cmp++;
    if (imem_we !== 1'b1 || done !== 1'b1 || count !== 7'(DEPTH)) begin
      n_bad++; $display("FAIL last_on_full: we=%b done=%b cnt=%0d required 1/1/%0d", imem_we, done, count, DEPTH);
    end
  endtask

  task automatic test_clear();
    restart();
    tick(0, 0, 1, 4'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 0);
    tick(0, 1, 1, 4'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b0 || count !== '0 || done !== 1'b0) begin
      n_bad++; $display("FAIL clear_drop: we=%b cnt=%0d done=%b required 0/0/0", imem_we, count, done);
    end
    idle_cycle();
    tick(0, 0, 1, 4'd4, 5'd6, 5'd7, 5'd8, 16'd0, 26'd0, 0);
    n_cmp++;
    if (imem_we !== 1'b1 || imem_addr !== 6'd0 || count !== 7'd1 || imem_wdata !== 32'h00C7402A) begin
      n_bad++; $display("FAIL clear_restart: we=%b addr=%0d cnt=%0d wdata=%h required 1/0/1/00c7402a",
                        imem_we, imem_addr, count, imem_wdata);
    end
  endtask

  task automatic test_illegal();
    logic [ADDR_W:0] c0;
    c0 = count;
    tick(0, 0, 1, 4'hF, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 0);
    n_cmp++;
    if (TRAP) begin
      if (imem_we !== 1'b0 || error !== 1'b1 || count !== c0) begin
        n_bad++; $display("FAIL illegal_trap: we=%b err=%b cnt=%0d required 0/1/%0d", imem_we, error, count, c0);
      end
    end else begin
      if (imem_we !== 1'b1 || imem_wdata !== 32'h0 || error !== 1'b0 || count !== c0 + 1'b1) begin
        n_bad++; $display("FAIL illegal_nop: we=%b wdata=%h err=%b cnt=%0d required 1/0/0/%0d",
                          imem_we, imem_wdata, error, count, c0 + 1'b1);
      end
    end
    restart();
    n_cmp++;
    if (error !== 1'b0) begin n_bad++; $display("FAIL clear_error: got %b required 0", error); end
  endtask

  task automatic test_random();
    logic v, c, r, l;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 49) == 0);
      tick(r, c, v, 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), l);
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_bad++; $display("FAIL rnd_ready @%0d: got %b required %b", n, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (imem_we !== exp_we || count !== (ADDR_W + 1)'(m_words) || done !== m_done || error !== m_err) begin
        n_bad++; $display("FAIL rnd_state @%0d: we=%b cnt=%0d done=%b err=%b required %b/%0d/%b/%b",
                          n, imem_we, count, done, error, exp_we, m_words, m_done, m_err);
      end
      if (exp_we) begin
        n_cmp++;
        if (imem_addr !== ADDR_W'(exp_addr) || imem_wdata !== exp_wdata) begin
          n_bad++; $display("FAIL rnd_write @%0d: addr=%0d wdata=%h required %0d/%h",
                            n, imem_addr, imem_wdata, exp_addr, exp_wdata);
        end
      end
    end
  endtask

  initial begin
    m_idle = 1; m_stop = 0; m_done = 0; m_err = 0; m_rdy = 0; m_words = 0; m_ptr = BASE;
    exp_we = 0; exp_addr = BASE; exp_wdata = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_last();
    test_full();
    test_full_last();
    test_clear();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
